// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, S-box table, xtime and the key-schedule FSM states
package aes_pkg;
   localparam int WORD_W = 32;
   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: SubWord, four parallel S-box lookups on one 32-bit word
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   output logic [WORD_W-1:0] word_o
);
   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
   end
endmodule

// File: rtl/key_schedule_engine.sv
// key_schedule_engine: iterative AES key expansion, one schedule word per clock
module key_schedule_engine
   import aes_pkg::*;
#(
   parameter int NK = 8,
   parameter int NR = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [255:0]           key_in,
   output logic                   busy,
   output logic                   done,
   output logic                   schedule_valid,
   output logic [128*(NR+1)-1:0]  key_schedule
);
   localparam int TOTAL = 4*(NR+1);
   if (!(NK == 4 || NK == 6 || NK == 8) || NR != NK + 6) begin : g_bad_params
      $error("key_schedule_engine: illegal NK/NR combination");
   end
   if (NK < 8) begin : g_narrow_key
      logic unused_key_bits;
      assign unused_key_bits = ^key_in[255-32*NK:0];
   end
   state_t state_q, state_d;
   logic [5:0] i_q, i_d;
   logic [2:0] j_q, j_d;
   logic [7:0] rcon_q, rcon_d;
   logic done_q, done_d;
   logic load;
   logic [WORD_W-1:0] w_q [TOTAL];
   logic [WORD_W-1:0] prev, sw_in, sw_out, temp, new_word;
   // one S-box bank serves both the RotWord step and the AES-256 mid-block SubWord
   aes_sub_word u_sub_word (.word_i(sw_in), .word_o(sw_out));
   assign prev     = w_q[i_q - 6'd1];
   assign sw_in    = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
   assign temp     = (j_q == 3'd0) ? sw_out ^ {rcon_q, 24'h0} : (NK == 8 && j_q == 3'd4) ? sw_out : prev;
   assign new_word = w_q[i_q - 6'(NK)] ^ temp;
   assign load     = start && state_q != EXPAND;
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      if (load) begin
         state_d = EXPAND;
         i_d     = 6'(NK);
         j_d     = '0;
         rcon_d  = RCON_INIT;
      end else if (state_q == EXPAND) begin
         i_d    = i_q + 6'd1;
         j_d    = (j_q == 3'(NK-1)) ? 3'd0 : j_q + 3'd1;
         rcon_d = (j_q == 3'd0) ? xtime(rcon_q) : rcon_q;
         state_d = (i_q == 6'(TOTAL-1)) ? DONE : EXPAND;
         done_d  = i_q == 6'(TOTAL-1);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         rcon_q  <= RCON_INIT;
         done_q  <= 1'b0;
         for (int k = 0; k < TOTAL; k++) w_q[k] <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
         if (load) for (int k = 0; k < NK; k++) w_q[k] <= key_in[255-32*k -: 32];
         else if (state_q == EXPAND) w_q[i_q] <= new_word;
      end
   end
   assign busy           = state_q == EXPAND;
   assign done           = done_q;
   assign schedule_valid = state_q == DONE;
   for (genvar g = 0; g < TOTAL; g++) begin : g_out
      assign key_schedule[128*(NR+1)-1-32*g -: 32] = w_q[g];
   end
endmodule

// File: tb/tb_key_schedule_engine.sv
// tb_key_schedule_engine: scoreboard bench for AES-128/192/256 key expansion
module tb_key_schedule_engine;
   typedef struct {
      int          dut;
      int          done_cyc;
      int          idx;
      logic [31:0] val;
   } exp_t;
   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY256A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY256B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   logic clk = 1'b0, rst = 1'b1;
   logic start128 = 1'b0, start192 = 1'b0, start256 = 1'b0;
   logic [255:0] key128 = '0, key192 = '0, key256 = '0;
   logic busy128, busy192, busy256, done128, done192, done256;
   logic valid128, valid192, valid256;
   logic [1407:0] ks128;
   logic [1663:0] ks192;
   logic [1919:0] ks256;
   int cyc = 0, total = 0, bad = 0;
   exp_t sb[$];

   key_schedule_engine #(.NK(4), .NR(10)) u_dut128 (.clk(clk), .rst(rst), .start(start128), .key_in(key128),
      .busy(busy128), .done(done128), .schedule_valid(valid128), .key_schedule(ks128));
   key_schedule_engine #(.NK(6), .NR(12)) u_dut192 (.clk(clk), .rst(rst), .start(start192), .key_in(key192),
      .busy(busy192), .done(done192), .schedule_valid(valid192), .key_schedule(ks192));
   key_schedule_engine #(.NK(8), .NR(14)) u_dut256 (.clk(clk), .rst(rst), .start(start256), .key_in(key256),
      .busy(busy256), .done(done256), .schedule_valid(valid256), .key_schedule(ks256));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic done_of(input int d);
      return d == 0 ? done128 : d == 1 ? done192 : done256;
   endfunction
   function automatic logic busy_of(input int d);
      return d == 0 ? busy128 : d == 1 ? busy192 : busy256;
   endfunction
   function automatic logic [31:0] word_of(input int d, input int idx);
      return d == 0 ? ks128[1407-32*idx -: 32] : d == 1 ? ks192[1663-32*idx -: 32] : ks256[1919-32*idx -: 32];
   endfunction
   function automatic int lat(input int d);
      return d == 0 ? 40 : d == 1 ? 46 : 52;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic expect_word(input int d, input int dc, input int idx, input logic [31:0] v);
      exp_t e;
      e.dut = d; e.done_cyc = dc; e.idx = idx; e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_done(input int d);
      int k, dc;
      logic [31:0] got;
      k = 0;
      while (k < sb.size() && sb[k].dut != d) k++;
      if (k == sb.size()) begin
         total++; bad++;
         $display("FAIL spurious_done dut%0d: got done at cycle %0d want no done", d, cyc);
         return;
      end
      dc = sb[k].done_cyc;
      chk($sformatf("latency dut%0d", d), 64'(cyc), 64'(dc));
      while (k < sb.size()) begin
         if (sb[k].dut == d && sb[k].done_cyc == dc) begin
            got = word_of(d, sb[k].idx);
            chk($sformatf("w[%0d] dut%0d", sb[k].idx, d), 64'(got), 64'(sb[k].val));
            sb.delete(k);
         end else k++;
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) if (done_of(d) === 1'b1) check_done(d);
   end

   task automatic kick(input int d, input logic [255:0] k, output int dc);
      @(negedge clk);
      if (d == 0) begin key128 = k; start128 = 1'b1; end
      if (d == 1) begin key192 = k; start192 = 1'b1; end
      if (d == 2) begin key256 = k; start256 = 1'b1; end
      dc = cyc + 1 + lat(d);
      @(negedge clk);
      start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
   endtask

   task automatic wait_done(input int d, input int repulse);
      int n, idle;
      bit seen;
      n = 1; idle = 0; seen = 0;
      while (n < 200 && !seen) begin
         if (done_of(d) === 1'b1) seen = 1;
         else begin
            if (busy_of(d) !== 1'b1) idle++;
            if (n == repulse) begin start256 = 1'b1; key256 = KEY256B; end
            else if (n == repulse + 1) begin start256 = 1'b0; key256 = 256'h0; end
            @(negedge clk);
            n++;
         end
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL timeout dut%0d: got no done in %0d cycles want done", d, n);
      end
      chk($sformatf("busy_gap dut%0d", d), 64'(idle), 64'd0);
   endtask

   initial begin
      int dc;
      repeat (2) @(negedge clk);
      chk("rst busy128", 64'(busy128), 0);   chk("rst done128", 64'(done128), 0);
      chk("rst valid128", 64'(valid128), 0); chk("rst ks128", 64'(|ks128), 0);
      chk("rst busy192", 64'(busy192), 0);   chk("rst done192", 64'(done192), 0);
      chk("rst valid192", 64'(valid192), 0); chk("rst ks192", 64'(|ks192), 0);
      chk("rst busy256", 64'(busy256), 0);   chk("rst done256", 64'(done256), 0);
      chk("rst valid256", 64'(valid256), 0); chk("rst ks256", 64'(|ks256), 0);
      rst = 1'b0;
      kick(0, KEY128, dc);
      expect_word(0, dc, 0, 32'h2b7e1516); expect_word(0, dc, 4, 32'ha0fafe17); expect_word(0, dc, 43, 32'hb6630ca6);
      wait_done(0, 0);
      kick(1, KEY192, dc);
      expect_word(1, dc, 0, 32'h8e73b0f7); expect_word(1, dc, 6, 32'hfe0c91f7); expect_word(1, dc, 51, 32'h01002202);
      wait_done(1, 0);
      kick(2, KEY256A, dc);
      expect_word(2, dc, 0, 32'h603deb10); expect_word(2, dc, 8, 32'h9ba35411);
      expect_word(2, dc, 12, 32'ha8b09c1a); expect_word(2, dc, 59, 32'h706c631e);
      wait_done(2, 0);
      chk("valid256 held", 64'(valid256), 64'd1);
      kick(2, KEY256A, dc);
      expect_word(2, dc, 0, 32'h603deb10); expect_word(2, dc, 8, 32'h9ba35411); expect_word(2, dc, 59, 32'h706c631e);
      wait_done(2, 9);
      kick(2, KEY256A, dc);
      repeat (18) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort busy256", 64'(busy256), 0);   chk("abort done256", 64'(done256), 0);
      chk("abort valid256", 64'(valid256), 0); chk("abort ks256", 64'(|ks256), 0);
      @(negedge clk);
      rst = 1'b0;
      kick(2, KEY256A, dc);
      expect_word(2, dc, 8, 32'h9ba35411); expect_word(2, dc, 12, 32'ha8b09c1a); expect_word(2, dc, 59, 32'h706c631e);
      wait_done(2, 0);
      kick(2, KEY256B, dc);
      chk("b2b valid256 drop", 64'(valid256), 0);
      chk("b2b busy256", 64'(busy256), 64'd1);
      expect_word(2, dc, 0, 32'h00010203); expect_word(2, dc, 8, 32'ha573c29f);
      expect_word(2, dc, 12, 32'h1651a8cd); expect_word(2, dc, 59, 32'h6d68de36);
      wait_done(2, 0);
      repeat (5) @(negedge clk);
      chk("scoreboard empty", 64'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 want finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/key_schedule_engine.md
Name: key_schedule_engine

Overview:
- Sequential AES key expansion (FIPS-197), directly upstream of the encrypt/decrypt datapaths.
- Replaces the combinational expansion with an iterative engine that generates one 32-bit schedule word per clock.
- Presents the full round-key schedule on the same MSB-first bus layout the encrypt/decrypt stages already consume, plus a valid flag.

Parameters:
- NK, 8, key length in 32-bit words; legal values 4, 6, 8.
- NR, 14, number of rounds; must equal NK+6. Any other combination is an elaboration error.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request expansion of key_in; sampled only in IDLE or DONE.
- key_in  input  256  cipher key, MSB-aligned; only bits [255 -: 32*NK] are used, the rest are ignored.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when the schedule is complete.
- schedule_valid  output  1  high from done until the next accepted start or rst.
- key_schedule  output  128*(NR+1)  words w[0]..w[4*NR+3]; w[0] occupies the most significant 32 bits.

Behaviour:
- Reset (asynchronous, any state): state IDLE; busy=0, done=0, schedule_valid=0, key_schedule=0; rcon=0x01; word index i=0; NK-modulo counter j=0. Asserting rst mid-expansion aborts it immediately and discards the partial schedule.
- Define TOTAL = 4*(NR+1), giving 44, 52 or 60 words.
- State IDLE
  - On start=1 at edge T:
    - Write w[0..NK-1] from key_in.
    - Set i=NK, j=0, rcon=0x01.
    - busy=1, schedule_valid=0.
    - Go to EXPAND.
- State EXPAND, one word written per edge:
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon), i.e. shift left by one and XOR 0x1B if the MSB was set.
  - Else if NK==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - i increments by 1; j increments and wraps at NK. No division or modulo hardware is used.
  - When i==TOTAL-1 is written: go to DONE, busy=0, done=1 for exactly one cycle, schedule_valid=1.
- Latency from the start edge to the done pulse (done visible in the cycle after edge T+TOTAL-NK):
  - AES-128: 40 cycles.
  - AES-192: 46 cycles.
  - AES-256: 52 cycles.
- State DONE
  - key_schedule is held stable.
  - start=1 is accepted exactly as in IDLE, so back-to-back expansions are supported.
- start while busy: ignored. No restart and no latching of the new key.
- key_in changing during EXPAND: no effect, because words are derived only from w[].
- rcon overflow: not reachable at legal parameter values. The maximum rcon used is 0x36 (AES-128); AES-256 uses up to 0x40.
- key_schedule is driven directly from the word registers. Consumers must qualify it with schedule_valid.

Decomposition:
- Shared package aes_pkg:
  - Constants WORD_W=32 and RCON_INIT=8'h01.
  - The SubWord byte-substitution table as a constant array.
  - An xtime function.
  - State enum {IDLE, EXPAND, DONE}.
- Sub-module aes_sub_word: combinational, four S-box lookups on a 32-bit word. The engine uses a single instance, shared by the RotWord path and the NK==8 j==4 path through an input mux.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - Expect w[4]=a0fafe17 and w[43]=b6630ca6.
  - done pulses once, 40 cycles after start.
  - busy is high in between.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - Expect w[6]=fe0c91f7 and w[51]=01002202.
  - Latency 46 cycles.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - Expect w[8]=9ba35411, w[12]=a8b09c1a and w[59]=706c631e.
  - Latency 52 cycles.
- AES-256, start re-pulsed at cycle 10 with a different key_in:
  - The re-pulse is ignored.
  - The schedule matches the first key, and done still arrives at cycle 52.
- AES-256, rst asserted at cycle 20 between clock edges:
  - Outputs go to 0 immediately, without waiting for an edge.
  - After release, a new start yields the correct schedule and 52-cycle latency.
- Back-to-back: start again in the cycle after done with the second key:
  - schedule_valid drops at the accepting edge.
  - The new schedule is correct, and done pulses 52 cycles later.
